// File: rtl/fifo_pkg.sv
// Shared helpers for the parameterisable-depth FIFO: width derivation,
// wrapped pointer increment, and the per-cycle operation encoding.
package fifo_pkg;

  localparam int unsigned MIN_DEPTH = 2;

  // Pointer width never drops below one bit, even for DEPTH == 2.
  function automatic int unsigned calc_pw(input int unsigned depth);
    return (depth <= 2) ? 1 : $clog2(depth);
  endfunction

  // Count must represent 0..DEPTH inclusive.
  function automatic int unsigned calc_cw(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction

  typedef enum logic [1:0] {
    OP_IDLE = 2'b00,
    OP_RD   = 2'b01,
    OP_WR   = 2'b10,
    OP_BOTH = 2'b11
  } fifo_op_e;

endpackage

// File: rtl/fifo_ptr_wrap.sv
// Registered FIFO pointer that advances on enable and wraps DEPTH-1 -> 0,
// so it never holds a value outside the memory range.
module fifo_ptr_wrap
  import fifo_pkg::*;
#(
  parameter int unsigned DEPTH = 13,
  parameter int unsigned PW    = calc_pw(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          en,
  output logic [PW-1:0] ptr
);

  logic [PW-1:0] ptr_reg;
  logic [PW-1:0] ptr_next;

  assign ptr_next = PW'(ptr_inc(32'(ptr_reg), DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_reg <= '0;
    end else if (en) begin
      ptr_reg <= ptr_next;
    end
  end

  assign ptr = ptr_reg;

endmodule

// File: rtl/fifo_param_depth.sv
// Single-clock show-ahead FIFO of arbitrary depth with registered status
// flags, occupancy count, programmable thresholds and error pulses.
module fifo_param_depth
  import fifo_pkg::*;
#(
  parameter int unsigned DWIDTH    = 8,
  parameter int unsigned DEPTH     = 13,
  parameter int unsigned AF_THRESH = DEPTH - 2,
  parameter int unsigned AE_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       wen,
  input  logic [DWIDTH-1:0]          din,
  output logic                       full,
  input  logic                       ren,
  output logic [DWIDTH-1:0]          dout,
  output logic                       empty,
  output logic [calc_cw(DEPTH)-1:0]  count,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic                       overflow,
  output logic                       underflow
);

  localparam int unsigned PW = calc_pw(DEPTH);
  localparam int unsigned CW = calc_cw(DEPTH);

  logic [CW-1:0]     count_reg;
  logic [CW-1:0]     count_next;
  logic              full_reg;
  logic              empty_reg;
  logic              almost_full_reg;
  logic              almost_empty_reg;
  logic              overflow_reg;
  logic              underflow_reg;

  logic              wr_ok;
  logic              rd_ok;
  fifo_op_e          op;

  logic [DWIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]     ptr_val [2];
  logic              ptr_en  [2];
  logic [PW-1:0]     rd_ptr;
  logic [PW-1:0]     wr_ptr;

  // Requests during reset are discarded so nothing lands in memory either.
  assign wr_ok = wen & ~full_reg & ~rst;
  assign rd_ok = ren & ~empty_reg & ~rst;
  assign op    = fifo_op_e'({wr_ok, rd_ok});

  // Index 0 is the read pointer, index 1 the write pointer.
  assign ptr_en[0] = rd_ok;
  assign ptr_en[1] = wr_ok;

  for (genvar gi = 0; gi < 2; gi++) begin : g_ptr
    fifo_ptr_wrap #(
      .DEPTH (DEPTH),
      .PW    (PW)
    ) u_ptr (
      .clk (clk),
      .rst (rst),
      .en  (ptr_en[gi]),
      .ptr (ptr_val[gi])
    );
  end

  assign rd_ptr = ptr_val[0];
  assign wr_ptr = ptr_val[1];

  always_comb begin
    count_next = count_reg;
    case (op)
      OP_WR:   count_next = count_reg + CW'(1);
      OP_RD:   count_next = count_reg - CW'(1);
      OP_BOTH: count_next = count_reg;
      default: count_next = count_reg;
    endcase
  end

  // Flags are derived from the post-edge occupancy so they stay registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      count_reg        <= '0;
      full_reg         <= 1'b0;
      empty_reg        <= 1'b1;
      almost_full_reg  <= 1'b0;
      almost_empty_reg <= 1'b1;
      overflow_reg     <= 1'b0;
      underflow_reg    <= 1'b0;
    end else begin
      count_reg        <= count_next;
      full_reg         <= (count_next == CW'(DEPTH));
      empty_reg        <= (count_next == '0);
      almost_full_reg  <= (count_next >= CW'(AF_THRESH));
      almost_empty_reg <= (count_next <= CW'(AE_THRESH));
      overflow_reg     <= wen & full_reg;
      underflow_reg    <= ren & empty_reg;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Show-ahead: head entry is visible without a read strobe.
  assign dout         = mem[rd_ptr];
  assign count        = count_reg;
  assign full         = full_reg;
  assign empty        = empty_reg;
  assign almost_full  = almost_full_reg;
  assign almost_empty = almost_empty_reg;
  assign overflow     = overflow_reg;
  assign underflow    = underflow_reg;

endmodule

// File: tb/tb_fifo_param_depth.sv
// Queue-model bench for fifo_param_depth (DWIDTH=4, DEPTH=13, AF=11, AE=2)
// with directed scenarios and literal spot checks.
module tb_fifo_param_depth;

  localparam int DW    = 4;
  localparam int DEPTH = 13;
  localparam int AF    = 11;
  localparam int AE    = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          wen;
  logic          ren;
  logic [DW-1:0] din;
  logic          full;
  logic          empty;
  logic [DW-1:0] dout;
  logic [3:0]    count;
  logic          almost_full;
  logic          almost_empty;
  logic          overflow;
  logic          underflow;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;

  int q[$];
  int m_ovf = 0;
  int m_unf = 0;

  fifo_param_depth #(
    .DWIDTH    (DW),
    .DEPTH     (DEPTH),
    .AF_THRESH (AF),
    .AE_THRESH (AE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .wen          (wen),
    .din          (din),
    .full         (full),
    .ren          (ren),
    .dout         (dout),
    .empty        (empty),
    .count        (count),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  always #5 clk = ~clk;

  function automatic void chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endfunction

  // Reference model: a plain queue of stored values.
  always @(posedge clk) begin
    if (rst) begin
      q.delete();
      m_ovf = 0;
      m_unf = 0;
    end else begin
      bit do_wr;
      bit do_rd;
      m_ovf = int'(wen && q.size() == DEPTH);
      m_unf = int'(ren && q.size() == 0);
      do_wr = wen && q.size() < DEPTH;
      do_rd = ren && q.size() > 0;
      if (do_rd) void'(q.pop_front());
      if (do_wr) q.push_back(int'(din));
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("count",        int'(count),        q.size());
      chk("empty",        int'(empty),        int'(q.size() == 0));
      chk("full",         int'(full),         int'(q.size() == DEPTH));
      chk("almost_full",  int'(almost_full),  int'(q.size() >= AF));
      chk("almost_empty", int'(almost_empty), int'(q.size() <= AE));
      chk("overflow",     int'(overflow),     m_ovf);
      chk("underflow",    int'(underflow),    m_unf);
      if (q.size() > 0) chk("dout", int'(dout), q[0]);
    end
  end

  // One clock cycle with the given request; returns at the following negedge.
  task automatic drive(input bit w, input bit r, input int d);
    wen = w;
    ren = r;
    din = DW'(d);
    @(negedge clk);
    $display("txn rst=%0d wen=%0d ren=%0d din=%h -> count=%0d empty=%0d full=%0d dout=%h ovf=%0d unf=%0d",
             rst, w, r, DW'(d), count, empty, full, dout, overflow, underflow);
    wen = 1'b0;
    ren = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; wen = 1'b0; ren = 1'b0; din = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    // Reset then idle
    drive(0, 0, 0);
    drive(0, 0, 0);
    chk("lit_reset_count", int'(count), 0);
    chk("lit_reset_empty", int'(empty), 1);
    chk("lit_reset_ae",    int'(almost_empty), 1);

    // Fill with 1..13
    for (int i = 1; i <= DEPTH; i++) begin
      drive(1, 0, i);
      chk("lit_fill_count", int'(count), i);
      chk("lit_fill_ae",    int'(almost_empty), int'(i <= 2));
      chk("lit_fill_af",    int'(almost_full),  int'(i >= 11));
      chk("lit_fill_full",  int'(full),         int'(i == 13));
    end
    drive(1, 0, 14);
    chk("lit_ovf_pulse", int'(overflow), 1);
    chk("lit_ovf_count", int'(count), 13);
    drive(0, 0, 0);
    chk("lit_ovf_clear", int'(overflow), 0);

    // Drain: 1..13 in order, then an underflow
    for (int i = 1; i <= DEPTH; i++) begin
      chk("lit_drain_dout", int'(dout), i);
      drive(0, 1, 0);
    end
    chk("lit_drain_empty", int'(empty), 1);
    drive(0, 1, 0);
    chk("lit_unf_pulse", int'(underflow), 1);
    drive(0, 0, 0);
    chk("lit_unf_clear", int'(underflow), 0);

    // Pointer wrap
    for (int i = 0; i < 10; i++) drive(1, 0, i);
    for (int i = 0; i < 10; i++) drive(0, 1, 0);
    for (int v = 10; v <= 14; v++) drive(1, 0, v);
    chk("lit_wrap_count", int'(count), 5);
    for (int v = 10; v <= 14; v++) begin
      chk("lit_wrap_dout", int'(dout), v);
      drive(0, 1, 0);
      chk("lit_wrap_cnt", int'(count), 14 - v);
    end

    // Simultaneous at count=5
    for (int v = 1; v <= 5; v++) drive(1, 0, v);
    drive(1, 1, 6);
    chk("lit_both_mid_count", int'(count), 5);
    for (int v = 2; v <= 6; v++) begin
      chk("lit_both_mid_dout", int'(dout), v);
      drive(0, 1, 0);
    end

    // Simultaneous at full
    for (int i = 0; i < DEPTH; i++) drive(1, 0, (i + 3) % 16);
    drive(1, 1, 15);
    chk("lit_both_full_count", int'(count), 12);
    chk("lit_both_full_ovf",   int'(overflow), 1);
    chk("lit_both_full_flag",  int'(full), 0);
    for (int i = 0; i < 12; i++) drive(0, 1, 0);

    // Simultaneous at empty
    drive(1, 1, 7);
    chk("lit_both_empty_count", int'(count), 1);
    chk("lit_both_empty_unf",   int'(underflow), 1);
    chk("lit_both_empty_dout",  int'(dout), 7);
    drive(0, 1, 0);

    // Reset mid-operation with 7 entries held; the write in the reset cycle is ignored
    for (int i = 0; i < 7; i++) drive(1, 0, i + 8);
    rst = 1'b1;
    drive(1, 0, 9);
    rst = 1'b0;
    chk("lit_rst_count", int'(count), 0);
    chk("lit_rst_empty", int'(empty), 1);
    chk("lit_rst_ae",    int'(almost_empty), 1);
    chk("lit_rst_full",  int'(full), 0);
    drive(1, 0, 3);
    chk("lit_post_rst_dout", int'(dout), 3);
    drive(0, 1, 0);
    chk("lit_post_rst_empty", int'(empty), 1);
    drive(0, 0, 0);

    chk_en = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
